// File: rtl/rt_mem_boot_loader_pkg.sv
// Shared types for the racetrack LiM port-B boot loader: FSM states and the
// port-B request bundle that the loader and the core both produce.
package rt_mem_pkg;

   localparam int RT_ADDR_W  = 22;
   localparam int RT_FUNCT_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      WAIT_VALID,
      GAP,
      SETTLE,
      DONE,
      ERR
   } loader_state_e;

   typedef struct packed {
      logic                  en;
      logic                  we;
      logic [RT_ADDR_W-1:0]  addr;
      logic [31:0]           wdata;
      logic [3:0]            be;
      logic [RT_FUNCT_W-1:0] funct;
      logic                  we_funct;
      logic [RT_ADDR_W-1:0]  range;
   } port_b_req_t;

endpackage

// File: rtl/rt_mem_boot_loader_port_b_mux.sv
// Port-B owner select: the loader request wins while it is busy, otherwise the
// core request passes straight through.
module rt_port_b_mux
   import rt_mem_pkg::*;
(
   input  logic        sel,
   input  port_b_req_t core_req,
   input  port_b_req_t ld_req,
   output port_b_req_t req
);

   assign req = sel ? ld_req : core_req;

endmodule

// File: rtl/rt_mem_boot_loader.sv
// Streams a firmware image into dp_ram port B one word per transaction, then
// hands port B back to the core and raises fetch_enable_o.
module rt_mem_boot_loader
   import rt_mem_pkg::*;
#(
   parameter int ADDR_W      = RT_ADDR_W,
   parameter int LIM_FUNCT_W = RT_FUNCT_W,
   parameter int TIMEOUT_CYC = 1024,
   parameter int SETTLE_CYC  = 3
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [ADDR_W-3:0]      num_words_i,
   input  logic                   src_valid_i,
   input  logic [31:0]            src_data_i,
   output logic                   src_ready_o,
   input  logic                   core_en_i,
   input  logic                   core_we_i,
   input  logic [ADDR_W-1:0]      core_addr_i,
   input  logic [31:0]            core_wdata_i,
   input  logic [3:0]             core_be_i,
   input  logic [LIM_FUNCT_W-1:0] core_funct_i,
   input  logic                   core_we_funct_i,
   input  logic [ADDR_W-1:0]      core_range_i,
   output logic                   core_rvalid_o,
   output logic [31:0]            core_rdata_o,
   output logic                   mem_en_o,
   output logic                   mem_we_o,
   output logic [ADDR_W-1:0]      mem_addr_o,
   output logic [31:0]            mem_wdata_o,
   output logic [3:0]             mem_be_o,
   output logic [LIM_FUNCT_W-1:0] mem_funct_o,
   output logic                   mem_we_funct_o,
   output logic [ADDR_W-1:0]      mem_range_o,
   input  logic                   mem_rvalid_i,
   input  logic [31:0]            mem_rdata_i,
   output logic                   busy_o,
   output logic                   fetch_enable_o,
   output logic                   err_o
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   loader_state_e     state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-3:0] cnt_q;
   logic [ADDR_W-3:0] num_q;
   logic [31:0]       data_q;
   logic [TMO_W-1:0]  tmo_q;
   logic              core_pend_q;
   logic              start_pend_q;
   logic              fe_q;
   logic              err_q;

   logic              busy;
   logic              go;
   logic [ADDR_W-3:0] nw;
   port_b_req_t       core_req;
   port_b_req_t       ld_req;
   port_b_req_t       req;

   assign busy = (state_q != IDLE) && (state_q != DONE);
   // A start waits until no core transaction is in flight, so its rvalid
   // never lands while the loader owns the port.
   assign go   = (start_i || start_pend_q) && !core_en_i && (!core_pend_q || mem_rvalid_i);
   assign nw   = start_i ? num_words_i : num_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         cnt_q        <= '0;
         num_q        <= '0;
         data_q       <= '0;
         tmo_q        <= '0;
         core_pend_q  <= 1'b0;
         start_pend_q <= 1'b0;
         fe_q         <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         if (busy) core_pend_q <= 1'b0;
         else      core_pend_q <= core_en_i || (core_pend_q && !mem_rvalid_i);

         case (state_q)
            IDLE: begin
               if (start_i) num_q <= num_words_i;
               if (go) begin
                  start_pend_q <= 1'b0;
                  addr_q       <= '0;
                  cnt_q        <= '0;
                  tmo_q        <= '0;
                  state_q      <= (nw == '0) ? SETTLE : FETCH;
               end else if (start_i) begin
                  start_pend_q <= 1'b1;
               end
            end
            FETCH: begin
               if (src_valid_i) begin
                  data_q  <= src_data_i;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               tmo_q   <= '0;
               state_q <= WAIT_VALID;
            end
            WAIT_VALID: begin
               if (mem_rvalid_i) begin
                  state_q <= GAP;
               end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                  err_q   <= 1'b1;
                  state_q <= ERR;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            GAP: begin
               addr_q <= addr_q + ADDR_W'(4);
               cnt_q  <= cnt_q + (ADDR_W-2)'(1);
               tmo_q  <= '0;
               state_q <= (cnt_q + (ADDR_W-2)'(1) == num_q) ? SETTLE : FETCH;
            end
            SETTLE: begin
               if (tmo_q == TMO_W'(SETTLE_CYC - 1)) begin
                  fe_q    <= 1'b1;
                  state_q <= DONE;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            DONE:    state_q <= DONE;
            ERR:     state_q <= ERR;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      core_req          = '0;
      core_req.en       = core_en_i;
      core_req.we       = core_we_i;
      core_req.addr     = core_addr_i;
      core_req.wdata    = core_wdata_i;
      core_req.be       = core_be_i;
      core_req.funct    = core_funct_i;
      core_req.we_funct = core_we_funct_i;
      core_req.range    = core_range_i;
   end

   // Loader always writes full words; only en pulses, the rest is held.
   always_comb begin
      ld_req       = '0;
      ld_req.en    = (state_q == ISSUE);
      ld_req.we    = 1'b1;
      ld_req.addr  = addr_q;
      ld_req.wdata = data_q;
      ld_req.be    = 4'hF;
   end

   rt_port_b_mux u_mux (
      .sel      (busy),
      .core_req (core_req),
      .ld_req   (ld_req),
      .req      (req)
   );

   assign mem_en_o       = req.en;
   assign mem_we_o       = req.we;
   assign mem_addr_o     = req.addr;
   assign mem_wdata_o    = req.wdata;
   assign mem_be_o       = req.be;
   assign mem_funct_o    = req.funct;
   assign mem_we_funct_o = req.we_funct;
   assign mem_range_o    = req.range;

   assign src_ready_o    = (state_q == FETCH) && src_valid_i;
   assign core_rvalid_o  = mem_rvalid_i && !busy;
   assign core_rdata_o   = mem_rdata_i;
   assign busy_o         = busy;
   assign fetch_enable_o = fe_q;
   assign err_o          = err_q;

endmodule
